// File: rtl/bp_be_regfile_nrmw.sv
// N-read / M-write flop-array register file with write->read bypass and held-address tracking.
// Latency: reads 1 cycle after rs_r_v_i; a write is visible on any port the cycle after it is issued.
// Backpressure: none; a read port with rs_r_v_i=0 holds its address and keeps tracking that register.
//
// Ports:
//   clk_i      clock, all state changes on posedge
//   reset_n_i  synchronous active-low reset (clears array and held addresses)
//   rs_r_v_i / rs_addr_i / rs_data_o   per-read-port enable, address, data (packed, port 0 in LSBs)
//   rd_w_v_i / rd_addr_i / rd_data_i   per-write-port enable, address, data (packed, port 0 in LSBs)
//
// Build option: define BP_BE_REGFILE_ZERO_REG_EN to hardwire register 0 to zero (integer file).
module bp_be_regfile_nrmw #(
    parameter  int data_width_p  = 64,
    parameter  int els_p         = 32,
    parameter  int read_ports_p  = 3,
    parameter  int write_ports_p = 2,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic [read_ports_p-1:0]                 rs_r_v_i,
    input  logic [read_ports_p*addr_width_lp-1:0]   rs_addr_i,
    output logic [read_ports_p*data_width_p-1:0]    rs_data_o,
    input  logic [write_ports_p-1:0]                rd_w_v_i,
    input  logic [write_ports_p*addr_width_lp-1:0]  rd_addr_i,
    input  logic [write_ports_p*data_width_p-1:0]   rd_data_i
);

    if (read_ports_p < 1 || read_ports_p > 4) begin : g_bad_read_ports
        $error("bp_be_regfile_nrmw: read_ports_p must be 1..4");
    end
    if (write_ports_p < 1 || write_ports_p > 3) begin : g_bad_write_ports
        $error("bp_be_regfile_nrmw: write_ports_p must be 1..3");
    end

    logic [data_width_p-1:0]  mem  [els_p];
    logic [addr_width_lp-1:0] held [read_ports_p];

    // Per-write-port decoded enable, address and data.
    logic                     wr_en   [write_ports_p];
    logic [addr_width_lp-1:0] wr_addr [write_ports_p];
    logic [data_width_p-1:0]  wr_data [write_ports_p];

    for (genvar j = 0; j < write_ports_p; j++) begin : g_wr
        assign wr_addr[j] = rd_addr_i[j*addr_width_lp +: addr_width_lp];
        assign wr_data[j] = rd_data_i[j*data_width_p +: data_width_p];
`ifdef BP_BE_REGFILE_ZERO_REG_EN
        // Writes to register 0 are dropped so the array entry stays zero.
        assign wr_en[j]   = rd_w_v_i[j] && (wr_addr[j] != '0);
`else
        assign wr_en[j]   = rd_w_v_i[j];
`endif
    end

    // Ports are visited in ascending order; the last non-blocking assignment
    // to an entry wins, so the highest-index port takes a same-address conflict.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int e = 0; e < els_p; e++) begin
                mem[e] <= '0;
            end
        end else begin
            for (int j = 0; j < write_ports_p; j++) begin
                if (wr_en[j]) begin
                    mem[wr_addr[j]] <= wr_data[j];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < read_ports_p; i++) begin
                held[i] <= '0;
            end
        end else begin
            for (int i = 0; i < read_ports_p; i++) begin
                if (rs_r_v_i[i]) begin
                    held[i] <= rs_addr_i[i*addr_width_lp +: addr_width_lp];
                end
            end
        end
    end

    // Output is the array entry selected by the registered address. Because the
    // array already holds the cycle-t writes at t+1, this gives write->read
    // bypass and held-address tracking without any path from rd_*_i.
    for (genvar i = 0; i < read_ports_p; i++) begin : g_rd
`ifdef BP_BE_REGFILE_ZERO_REG_EN
        assign rs_data_o[i*data_width_p +: data_width_p] =
            (held[i] == '0) ? '0 : mem[held[i]];
`else
        assign rs_data_o[i*data_width_p +: data_width_p] = mem[held[i]];
`endif
    end

endmodule
